// File: rtl/smart_home_pkg.sv
// Shared constants for the smart-home event scheduler: display codes, FSM states,
// sensor indices (index order is grant priority) and small lookup helpers.
package smart_home_pkg;

  localparam int unsigned N_SENS = 4;

  localparam logic [2:0] DISP_IDLE = 3'd0;
  localparam logic [2:0] DISP_FD   = 3'd1;
  localparam logic [2:0] DISP_RD   = 3'd2;
  localparam logic [2:0] DISP_FIRE = 3'd3;
  localparam logic [2:0] DISP_WIN  = 3'd4;
  localparam logic [2:0] DISP_HEAT = 3'd5;
  localparam logic [2:0] DISP_COOL = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    FIRE  = 2'd2
  } fsm_state_e;

  localparam logic [1:0] IDX_FA = 2'd0;
  localparam logic [1:0] IDX_FD = 2'd1;
  localparam logic [1:0] IDX_RD = 2'd2;
  localparam logic [1:0] IDX_W  = 2'd3;

  // Lowest set index wins, which is the highest-priority pending sensor.
  function automatic logic [1:0] pick_highest(input logic [N_SENS-1:0] pend);
    pick_highest = IDX_W;
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (pend[i]) pick_highest = 2'(i);
    end
  endfunction

  function automatic logic [2:0] sensor_disp(input logic [1:0] idx);
    case (idx)
      IDX_FD:  sensor_disp = DISP_FD;
      IDX_RD:  sensor_disp = DISP_RD;
      IDX_W:   sensor_disp = DISP_WIN;
      default: sensor_disp = DISP_FIRE;
    endcase
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer; emits the
// debounced level and a one-cycle registered pulse on each debounced rising edge.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic       sync1_q, sync2_q;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == 4'(DEBOUNCE_CYC - 1)) level_d = sync2_q;
      else                               cnt_d   = cnt_q + 4'd1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so the synchronizer stages shift instead of collapsing into one flop.
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/home_event_scheduler.sv
// Latches debounced sensor events and grants them one at a time (fire preempts),
// plus a hysteresis thermostat; all actuator and display outputs are registered.
module home_event_scheduler
  import smart_home_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned HOLD_CYC     = 8,
  parameter logic [6:0]  T_HEAT       = 7'd50,
  parameter logic [6:0]  T_COOL       = 7'd80,
  parameter logic [6:0]  HYST         = 7'd2
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic       SFA,
  input  logic [6:0] ST,
  output logic       fdoor,
  output logic       rdoor,
  output logic       winbuzz,
  output logic       alarmbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic       busy
);

  localparam logic [7:0] HOLD_M1  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] HEAT_OFF = {1'b0, T_HEAT} + {1'b0, HYST};
  localparam logic [7:0] COOL_OFF = {1'b0, T_COOL} - {1'b0, HYST};

  logic [N_SENS-1:0] raw_vec, lvl_vec, rise_vec;
  logic [N_SENS-1:0] pend_q, pend_d, pend_clr, pend_set;
  fsm_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [7:0]        hold_q, hold_d;
  logic              heat_req_q, heat_req_d, cool_req_q, cool_req_d;
  logic              fdoor_q, fdoor_d, rdoor_q, rdoor_d, winbuzz_q, winbuzz_d;
  logic              alarmbuzz_q, alarmbuzz_d, heater_q, heater_d, cooler_q, cooler_d;
  logic [2:0]        display_q, display_d;
  logic              serve_d;

  // Bit positions follow IDX_*, so vector index order is also grant priority.
  assign raw_vec = {SW, SRD, SFD, SFA};

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk   (clk),
      .rst_n (Rst),
      .raw   (raw_vec[i]),
      .level (lvl_vec[i]),
      .rise  (rise_vec[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    pend_clr = '0;
    pend_set = '0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          grant_d           = pick_highest(pend_q);
          pend_clr[grant_d] = 1'b1;
          hold_d            = HOLD_M1;
          state_d           = (grant_d == IDX_FA) ? FIRE : SERVE;
        end
      end
      SERVE: begin
        if (pend_q[IDX_FA]) begin
          // Aborted service is re-queued so it is granted again after the fire clears.
          pend_set[grant_q]  = 1'b1;
          pend_clr[IDX_FA]   = 1'b1;
          grant_d            = IDX_FA;
          hold_d             = HOLD_M1;
          state_d            = FIRE;
        end else if (hold_q == '0) begin
          if (lvl_vec[grant_q]) hold_d  = HOLD_M1;
          else                  state_d = IDLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      FIRE: begin
        if (lvl_vec[IDX_FA])    hold_d  = HOLD_M1;
        else if (hold_q == '0)  state_d = IDLE;
        else                    hold_d  = hold_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    pend_d = (pend_q & ~pend_clr) | pend_set | rise_vec;
  end

  always_comb begin
    heat_req_d = heat_req_q ? ({1'b0, ST} < HEAT_OFF) : (ST < T_HEAT);
    cool_req_d = cool_req_q ? ({1'b0, ST} > COOL_OFF) : (ST > T_COOL);

    serve_d     = (state_d == SERVE);
    fdoor_d     = serve_d && (grant_d == IDX_FD);
    rdoor_d     = serve_d && (grant_d == IDX_RD);
    winbuzz_d   = serve_d && (grant_d == IDX_W);
    alarmbuzz_d = (state_d == FIRE);
    heater_d    = heat_req_d && !alarmbuzz_d;
    cooler_d    = cool_req_d && !alarmbuzz_d;

    if (serve_d)          display_d = sensor_disp(grant_d);
    else if (alarmbuzz_d) display_d = DISP_FIRE;
    else if (heater_d)    display_d = DISP_HEAT;
    else if (cooler_d)    display_d = DISP_COOL;
    else                  display_d = DISP_IDLE;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      grant_q     <= IDX_FA;
      hold_q      <= '0;
      pend_q      <= '0;
      heat_req_q  <= 1'b0;
      cool_req_q  <= 1'b0;
      fdoor_q     <= 1'b0;
      rdoor_q     <= 1'b0;
      winbuzz_q   <= 1'b0;
      alarmbuzz_q <= 1'b0;
      heater_q    <= 1'b0;
      cooler_q    <= 1'b0;
      display_q   <= DISP_IDLE;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      heat_req_q  <= heat_req_d;
      cool_req_q  <= cool_req_d;
      fdoor_q     <= fdoor_d;
      rdoor_q     <= rdoor_d;
      winbuzz_q   <= winbuzz_d;
      alarmbuzz_q <= alarmbuzz_d;
      heater_q    <= heater_d;
      cooler_q    <= cooler_d;
      display_q   <= display_d;
    end
  end

  assign fdoor     = fdoor_q;
  assign rdoor     = rdoor_q;
  assign winbuzz   = winbuzz_q;
  assign alarmbuzz = alarmbuzz_q;
  assign heater    = heater_q;
  assign cooler    = cooler_q;
  assign display   = display_q;
  assign busy      = (state_q != IDLE);

  a_thermo_excl: assert property (@(posedge clk) disable iff (!Rst) !(heat_req_q && cool_req_q));

endmodule

// File: tb/tb_home_event_scheduler.sv
// Self-checking bench: directed scenarios plus random sensor/temperature stimulus,
// every output compared each cycle against a behavioural model of the scheduler.
module tb_home_event_scheduler;

  localparam int D    = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0, Rst = 1'b0;
  logic       SFD = 1'b0, SRD = 1'b0, SW = 1'b0, SFA = 1'b0;
  logic [6:0] ST = 7'd65;
  logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, busy;
  logic [2:0] display;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: mode 0 idle, 1 serving, 2 fire; m_left counts remaining cycles.
  int         m_mode, m_who, m_left;
  bit [3:0]   m_s1, m_s2, m_lvl, m_rise, m_pend;
  bit [15:0]  m_hist [4];
  bit         m_heat, m_cool;

  logic [2:0] seq[$];
  int         rv[$], rl[$];
  int         n;
  bit         seen;

  home_event_scheduler dut (
    .clk(clk), .Rst(Rst), .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST),
    .fdoor(fdoor), .rdoor(rdoor), .winbuzz(winbuzz), .alarmbuzz(alarmbuzz),
    .heater(heater), .cooler(cooler), .display(display), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, display, busy};
  endfunction

  function automatic logic [9:0] exp_vec();
    logic       h, c;
    logic [2:0] d;
    h = m_heat && (m_mode != 2);
    c = m_cool && (m_mode != 2);
    if (m_mode == 1)      d = (m_who == 1) ? 3'd1 : (m_who == 2) ? 3'd2 : 3'd4;
    else if (m_mode == 2) d = 3'd3;
    else                  d = h ? 3'd5 : (c ? 3'd6 : 3'd0);
    return {m_mode == 1 && m_who == 1, m_mode == 1 && m_who == 2, m_mode == 1 && m_who == 3,
            m_mode == 2, h, c, d, m_mode != 0};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_who = 0; m_left = 0;
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_pend = '0;
    m_heat = 1'b0; m_cool = 1'b0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  endtask

  task automatic model_edge();
    bit [3:0] raw, nl, pend;
    bit       diff;
    raw = {SW, SRD, SFD, SFA};
    nl  = m_lvl;
    // A level flips once the last D synchronized samples all disagree with it.
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = {m_hist[i][14:0], m_s2[i]};
      diff = 1'b1;
      for (int k = 0; k < D; k++) if (m_hist[i][k] == m_lvl[i]) diff = 1'b0;
      if (diff) nl[i] = ~m_lvl[i];
    end
    pend = m_pend;
    case (m_mode)
      0: if (pend != 0) begin
        for (int i = 3; i >= 0; i--) if (pend[i]) m_who = i;
        pend[m_who] = 1'b0;
        m_left = HOLD;
        m_mode = (m_who == 0) ? 2 : 1;
      end
      1: if (pend[0]) begin
        pend[0] = 1'b0;
        pend[m_who] = 1'b1;
        m_who = 0; m_mode = 2; m_left = HOLD;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_lvl[m_who]) m_left = HOLD;
          else              m_mode = 0;
        end
      end
      default: if (m_lvl[0]) m_left = HOLD;
      else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
    m_pend = pend | m_rise;
    m_rise = nl & ~m_lvl;
    m_lvl  = nl;
    m_s2   = m_s1;
    m_s1   = raw;
    if (ST < 7'd50)       m_heat = 1'b1;
    else if (ST >= 7'd52) m_heat = 1'b0;
    if (ST > 7'd80)       m_cool = 1'b1;
    else if (ST <= 7'd78) m_cool = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (Rst) model_edge();
    #1;
    check("cycle", 32'(dut_vec()), 32'(exp_vec()));
  endtask

  task automatic settle();
    SFD = 0; SRD = 0; SW = 0; SFA = 0;
    repeat (40) tick();
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_state", 32'(dut_vec()), 32'd0);
    repeat (3) tick();
    Rst = 1'b1;
    repeat (5) tick();

    // Glitch shorter than the debounce window must not grant.
    SFD = 1; tick(); tick(); SFD = 0;
    seen = 0;
    repeat (22) begin tick(); if (fdoor) seen = 1; end
    check("short_pulse", 32'(seen), 32'd0);

    // Raw rise to actuator high takes DEBOUNCE_CYC+4 cycles.
    SFD = 1; n = 0;
    while (!fdoor && n < 30) begin tick(); n++; end
    check("latency", n, D + 4);
    check("fdoor_disp", 32'(display), 32'd1);
    repeat (12) tick();
    SFD = 0; n = 0;
    while (fdoor && n < 40) begin tick(); n++; end
    check("fdoor_drop", 32'(fdoor), 32'd0);
    settle();

    // Three simultaneous events are served in priority order with one idle cycle between.
    SFD = 1; SRD = 1; SW = 1;
    repeat (5) begin tick(); seq.push_back(display); end
    SFD = 0; SRD = 0; SW = 0;
    repeat (40) begin tick(); seq.push_back(display); end
    for (int i = 0; i < seq.size(); i++) begin
      if (rv.size() == 0 && seq[i] == 3'd0) continue;
      if (rv.size() > 0 && rv[$] == int'(seq[i])) rl[$] = rl[$] + 1;
      else begin rv.push_back(int'(seq[i])); rl.push_back(1); end
    end
    begin
      int ev[5] = '{1, 0, 2, 0, 4};
      int el[5] = '{8, 1, 8, 1, 8};
      for (int i = 0; i < 5; i++)
        check("seq_run", (i < rv.size()) ? rv[i] * 256 + rl[i] : -1, ev[i] * 256 + el[i]);
    end
    settle();

    // Fire preempts a window service; the window is re-granted afterwards.
    SW = 1; n = 0;
    while (!winbuzz && n < 20) begin tick(); n++; end
    check("win_grant", 32'(winbuzz), 32'd1);
    SFA = 1;
    repeat (5) tick();
    SW = 0;
    tick();
    SFA = 0; n = 0;
    while (!alarmbuzz && n < 20) begin tick(); n++; end
    check("fire_grant", 32'(alarmbuzz), 32'd1);
    check("fire_winoff", 32'(winbuzz), 32'd0);
    check("fire_disp", 32'(display), 32'd3);
    n = 0;
    while (display != 3'd4 && n < 60) begin tick(); n++; end
    check("win_regrant", 32'(display), 32'd4);
    settle();

    // Thermostat hysteresis while idle.
    ST = 7'd60; tick();
    ST = 7'd45; tick(); check("heat_on",   32'(heater), 32'd1); check("heat_disp", 32'(display), 32'd5);
    ST = 7'd51; tick(); check("heat_hold", 32'(heater), 32'd1);
    ST = 7'd52; tick(); check("heat_off",  32'(heater), 32'd0);
    ST = 7'd85; tick(); check("cool_on",   32'(cooler), 32'd1); check("cool_disp", 32'(display), 32'd6);
    ST = 7'd79; tick(); check("cool_hold", 32'(cooler), 32'd1);
    ST = 7'd78; tick(); check("cool_off",  32'(cooler), 32'd0);

    // Heater is forced off during fire and restored on return to idle.
    ST = 7'd45; repeat (3) tick();
    SFA = 1; repeat (6) tick(); SFA = 0; n = 0;
    while (!alarmbuzz && n < 20) begin tick(); n++; end
    check("fire_heat_off", 32'(heater), 32'd0);
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    check("heat_restore", 32'(heater), 32'd1);
    ST = 7'd65;
    settle();

    // Asynchronous reset in the middle of a service.
    SFD = 1; n = 0;
    while (!fdoor && n < 20) begin tick(); n++; end
    Rst = 1'b0;
    #1;
    check("async_rst", 32'(dut_vec()), 32'd0);
    model_reset();
    SFD = 0;
    tick(); tick();
    Rst = 1'b1;
    settle();

    // Random sensor activity and temperature drift.
    repeat (3000) begin
      int t;
      if ($urandom_range(0, 19) == 0) SFD = ~SFD;
      if ($urandom_range(0, 19) == 0) SRD = ~SRD;
      if ($urandom_range(0, 19) == 0) SW  = ~SW;
      if ($urandom_range(0, 59) == 0) SFA = ~SFA;
      if ($urandom_range(0, 99) == 0) ST = 7'($urandom_range(40, 90));
      else if ($urandom_range(0, 3) == 0) begin
        t = int'(ST) + int'($urandom_range(0, 6)) - 3;
        if (t < 0) t = 0;
        if (t > 127) t = 127;
        ST = 7'(t);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/home_event_scheduler.md
Name: home_event_scheduler

Overview:
- Sequences the smart-home actuators by latching debounced sensor events and granting them one at a time under fixed priority.
- Priority order: fire alarm, front door, rear door, window.
- Also runs a hysteresis thermostat from the 7-bit temperature input.
- Drives the door/buzzer/heater/cooler outputs and the 3-bit display code consumed by the house status panel.

Parameters:
DEBOUNCE_CYC, 4, consecutive equal synchronized samples needed to accept a sensor level change (1..15)
HOLD_CYC, 8, cycles an actuator stays granted per service (1..255)
T_HEAT, 7'd50, heat request sets when ST < T_HEAT
T_COOL, 7'd80, cool request sets when ST > T_COOL
HYST, 7'd2, thermostat hysteresis; requires T_HEAT+HYST < T_COOL-HYST

Ports:
clk  in  1  system clock, rising edge
Rst  in  1  asynchronous active-low reset
SFD  in  1  front-door sensor, raw async
SRD  in  1  rear-door sensor, raw async
SW  in  1  window sensor, raw async
SFA  in  1  fire-alarm sensor, raw async
ST  in  7  temperature, unsigned, synchronous to clk
fdoor  out  1  front-door actuator
rdoor  out  1  rear-door actuator
winbuzz  out  1  window buzzer
alarmbuzz  out  1  fire buzzer
heater  out  1  heater enable
cooler  out  1  cooler enable
display  out  3  status code
busy  out  1  high in SERVE or FIRE

Behaviour:
- Reset: clk and a single async reset; reset is asynchronous, active-low. Rst low clears all outputs to 0, display to 3'd0, all sync flops, debounce counters, pending bits, hold counter and thermostat state, and puts the FSM in IDLE. Reset mid-service discards all pending events.
- Input path:
  - SFD/SRD/SW/SFA each pass a 2-flop synchronizer, then a debounce cell.
  - The debounced level updates after DEBOUNCE_CYC consecutive synchronized samples differ from it. Any mismatch-free sample resets the counter.
  - A debounced rising edge sets that sensor's pending bit. Repeat edges while the bit is already set are absorbed.
- Display codes: 0 idle, 1 front door, 2 rear door, 3 fire, 4 window, 5 idle+heating, 6 idle+cooling.
- FSM states and transitions:
  - IDLE: if any pending bit is set, grant the highest-priority one, clear its bit, load hold=HOLD_CYC-1, and go to FIRE (for SFA) or SERVE (otherwise). Outputs are registered and assert on the cycle after the decision.
  - SERVE: the one-hot actuator for the granted sensor is high, with display set to its code. hold decrements each cycle. At hold==0:
    - if that sensor's debounced level is still high, reload and stay;
    - else deassert and return to IDLE.
    - There is exactly one IDLE cycle between consecutive grants.
  - Preemption: a fire pending bit seen in SERVE aborts the service. The next state is FIRE, and the aborted sensor's pending bit is re-set.
  - FIRE: alarmbuzz=1, display=3, heater=cooler=0. hold reloads every cycle while debounced SFA is high. After SFA falls, exit to IDLE once hold reaches 0.
- Lower-priority events arriving during SERVE/FIRE stay pending and are never lost.
- Latency: from raw input rising with stable level (FSM idle) to actuator high is exactly DEBOUNCE_CYC+4 cycles.
- Thermostat:
  - heat_req sets when ST<T_HEAT and clears when ST>=T_HEAT+HYST.
  - cool_req sets when ST>T_COOL and clears when ST<=T_COOL-HYST.
  - The two requests are mutually exclusive by construction; an assertion checks it.
  - heater/cooler are registered from heat_req/cool_req, one cycle after ST, and are forced 0 in FIRE.
- Display priority: the grant code wins; otherwise 5 if heater, 6 if cooler, else 0.
- Simultaneous pending edges resolve by priority in a single cycle.

Decomposition:
- Package smart_home_pkg holds:
  - display code localparams (DISP_IDLE..DISP_COOL);
  - FSM state enum (IDLE, SERVE, FIRE);
  - sensor index constants (IDX_FA=0, IDX_FD=1, IDX_RD=2, IDX_W=3), which also set priority order.
- One sub-module, sensor_debounce: synchronizer, counter, level and rise output, parameterized by DEBOUNCE_CYC. It is instantiated four times.

Test Plan:
- Defaults; Rst low at cycle 0, released at 3 → all outputs 0, display=0 until stimulus; Rst dropped mid-SERVE → outputs 0 immediately (async).
- SFD pulse high 2 cycles (< DEBOUNCE_CYC) → no fdoor. SFD high 20 cycles → fdoor high at cycle 8 after rise; after SFD falls, fdoor drops at the first hold expiry following debounced fall; display=1 throughout.
- SFD, SRD, SW rise in the same cycle → fdoor for 8 cycles, 1 idle cycle, rdoor 8 cycles, 1 idle, winbuzz 8 cycles; display sequence 1,0,2,0,4.
- SW serving, SFA rises → winbuzz drops and alarmbuzz rises with display=3; after SFA low, window re-granted (display=4).
- ST ramps 60→45→51→52 → heater on at ST=45 (+1 cycle), stays on at 51, off at 52; ST 85→78 → cooler on, off at 78; display 5/6 while idle.
- Heater on and SFA asserted → heater forced 0 during FIRE, restored after return to IDLE if ST still <50.
